// File: rtl/res_seq.sv
// Reset sequencer: synchronises an external active-low reset request, holds for a
// clean-input window, then releases N_CH reset channels one after another.
module res_seq #(
  parameter int SYNC_STAGES = 8,
  parameter int N_CH        = 4,
  parameter int HOLD_CYC    = 16,
  parameter int STAGGER_CYC = 4
) (
  input  logic            clk,
  input  logic            res,
  input  logic            res_n_in,
  input  logic            sw_res_req,
  output logic [N_CH-1:0] res_n_out,
  output logic            seq_done,
  output logic [1:0]      res_cause
);

  typedef enum logic [1:0] {ASSERT, HOLD, RELEASE, RUN} state_t;

  localparam logic [15:0]     HOLD_LAST   = 16'(HOLD_CYC - 1);
  localparam logic [15:0]     STAG_LAST   = 16'(STAGGER_CYC - 1);
  localparam logic [4:0]      LAST_IDX    = 5'(N_CH - 1);
  localparam logic [N_CH-1:0] ONE         = N_CH'(1);
  localparam logic [N_CH-1:0] ALL_ONES    = '1;
  // With no stagger, or a single channel, the first release is also the last one.
  localparam bit              ALL_AT_ONCE = (STAGGER_CYC == 0) || (N_CH == 1);

  localparam logic [1:0] CAUSE_RES = 2'b00;
  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  logic [SYNC_STAGES-1:0] chain;
  logic                   ext_ok;
  state_t                 state;
  logic [15:0]            cnt;
  logic [4:0]             idx;

  assign ext_ok = &chain;

  always_ff @(posedge clk) begin
    if (res) chain <= '0;
    else     chain <= {chain[SYNC_STAGES-2:0], res_n_in};
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state     <= ASSERT;
      cnt       <= '0;
      idx       <= '0;
      res_n_out <= '0;
      seq_done  <= 1'b0;
      res_cause <= CAUSE_RES;
    end else begin
      case (state)
        ASSERT: begin
          res_n_out <= '0;
          seq_done  <= 1'b0;
          if (ext_ok) begin
            state <= HOLD;
            cnt   <= '0;
          end
        end
        HOLD: begin
          if (!ext_ok) begin
            state     <= ASSERT;
            cnt       <= '0;
            res_cause <= CAUSE_EXT;
          end else if (sw_res_req) begin
            cnt       <= '0;
            res_cause <= CAUSE_SW;
          end else if (cnt == HOLD_LAST) begin
            cnt <= '0;
            if (ALL_AT_ONCE) begin
              res_n_out <= ALL_ONES;
              seq_done  <= 1'b1;
              idx       <= LAST_IDX;
              state     <= RUN;
            end else begin
              res_n_out <= ONE;
              idx       <= 5'd1;
              state     <= RELEASE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RELEASE, RUN: begin
          // External loss wins over a simultaneous software request.
          if (!ext_ok || sw_res_req) begin
            state     <= ASSERT;
            cnt       <= '0;
            idx       <= '0;
            res_n_out <= '0;
            seq_done  <= 1'b0;
            res_cause <= ext_ok ? CAUSE_SW : CAUSE_EXT;
          end else if (state == RELEASE) begin
            if (cnt == STAG_LAST) begin
              res_n_out <= res_n_out | (ONE << idx);
              cnt       <= '0;
              idx       <= idx + 5'd1;
              if (idx == LAST_IDX) begin
                state    <= RUN;
                seq_done <= 1'b1;
              end
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        default: state <= ASSERT;
      endcase
    end
  end

endmodule

// File: tb/tb_res_seq.sv
// Bench for res_seq: three configurations driven by shared inputs, checked against a
// release-time model (bit k of a sequence releases at hold_start + HOLD + k*STAGGER).
module tb_res_seq;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic res_n_in = 1'b1;
  logic sw_res_req = 1'b0;

  logic [3:0] o0, o1;
  logic [0:0] o2;
  logic       d0, d1, d2;
  logic [1:0] c0, c1, c2;

  int n_vec = 0;
  int n_mis = 0;
  int ed = 0;

  int cs[3] = '{8, 8, 2};
  int cn[3] = '{4, 4, 1};
  int ch[3] = '{16, 16, 1};
  int cg[3] = '{4, 0, 5};

  int hr[3], act[3], t0[3], cause_m[3], exp_out[3], exp_done[3];

  res_seq u0 (.clk(clk), .res(res), .res_n_in(res_n_in), .sw_res_req(sw_res_req),
              .res_n_out(o0), .seq_done(d0), .res_cause(c0));
  res_seq #(.SYNC_STAGES(8), .N_CH(4), .HOLD_CYC(16), .STAGGER_CYC(0)) u1 (
              .clk(clk), .res(res), .res_n_in(res_n_in), .sw_res_req(sw_res_req),
              .res_n_out(o1), .seq_done(d1), .res_cause(c1));
  res_seq #(.SYNC_STAGES(2), .N_CH(1), .HOLD_CYC(1), .STAGGER_CYC(5)) u2 (
              .clk(clk), .res(res), .res_n_in(res_n_in), .sw_res_req(sw_res_req),
              .res_n_out(o2), .seq_done(d2), .res_cause(c2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h at edge %0d", tag, got, exp, ed);
    end
  endtask

  // Number of channels released e edges after the hold window started.
  function automatic int nrel(int i, int e);
    int r;
    if (e < ch[i]) return 0;
    if (cg[i] == 0) return cn[i];
    r = 1 + (e - ch[i]) / cg[i];
    return (r > cn[i]) ? cn[i] : r;
  endfunction

  task automatic model_step(int i);
    int  n;
    bit  ext_pre;
    if (res) begin
      hr[i] = 0; act[i] = 0; cause_m[i] = 0;
    end else begin
      ext_pre = (hr[i] >= cs[i]);
      hr[i] = res_n_in ? ((hr[i] < cs[i]) ? hr[i] + 1 : hr[i]) : 0;
      if (act[i] == 0) begin
        if (ext_pre) begin act[i] = 1; t0[i] = ed; end
      end else if (!ext_pre) begin
        act[i] = 0; cause_m[i] = 1;
      end else if (sw_res_req) begin
        cause_m[i] = 2;
        if (nrel(i, ed - 1 - t0[i]) == 0) t0[i] = ed;
        else act[i] = 0;
      end
    end
    n = (act[i] != 0) ? nrel(i, ed - t0[i]) : 0;
    exp_out[i]  = (1 << n) - 1;
    exp_done[i] = (act[i] != 0 && n == cn[i]) ? 1 : 0;
  endtask

  task automatic step();
    @(posedge clk);
    ed++;
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    check("u0_out", 32'(o0), 32'(exp_out[0]));
    check("u0_done", 32'(d0), 32'(exp_done[0]));
    check("u0_cause", 32'(c0), 32'(cause_m[0]));
    check("u1_out", 32'(o1), 32'(exp_out[1]));
    check("u1_done", 32'(d1), 32'(exp_done[1]));
    check("u1_cause", 32'(c1), 32'(cause_m[1]));
    check("u2_out", 32'(o2), 32'(exp_out[2]));
    check("u2_done", 32'(d2), 32'(exp_done[2]));
    check("u2_cause", 32'(c2), 32'(cause_m[2]));
  endtask

  task automatic run_to(int e);
    while (ed < e) step();
  endtask

  initial begin
    int r;
    int low_len;
    bit seen;

    // Reset; the last reset edge is numbered edge 0.
    res = 1'b1; res_n_in = 1'b1; sw_res_req = 1'b0;
    repeat (3) step();
    check("rst_out0", 32'(o0), 32'h0);
    check("rst_done0", 32'(d0), 32'h0);
    check("rst_cause0", 32'(c0), 32'h0);
    ed = 0;
    res = 1'b0;

    // Default power-up release timing, plus the all-at-once configuration.
    run_to(24);
    check("pu_e24_out0", 32'(o0), 32'h0);
    check("pu_e24_out1", 32'(o1), 32'h0);
    step();
    check("pu_e25_out0", 32'(o0), 32'h1);
    check("pu_e25_out1", 32'(o1), 32'hf);
    check("pu_e25_done1", 32'(d1), 32'h1);
    check("pu_e25_done0", 32'(d0), 32'h0);
    run_to(29);
    check("pu_e29_out0", 32'(o0), 32'h3);
    run_to(33);
    check("pu_e33_out0", 32'(o0), 32'h7);
    run_to(36);
    check("pu_e36_done0", 32'(d0), 32'h0);
    step();
    check("pu_e37_out0", 32'(o0), 32'hf);
    check("pu_e37_done0", 32'(d0), 32'h1);

    // One-cycle external glitch in RUN.
    run_to(45);
    res_n_in = 1'b0;
    step();
    res_n_in = 1'b1;
    step();
    check("gl_out0", 32'(o0), 32'h0);
    check("gl_done0", 32'(d0), 32'h0);
    check("gl_cause0", 32'(c0), 32'h1);
    run_to(70);
    check("gl_pre_out0", 32'(o0), 32'h0);
    step();
    check("gl_rel_out0", 32'(o0), 32'h1);
    check("gl_rel_out1", 32'(o1), 32'hf);

    // Software request while HOLD count is 10 restarts the hold window.
    res_n_in = 1'b0;
    step();
    res_n_in = 1'b1;
    run_to(91);
    sw_res_req = 1'b1;
    step();
    sw_res_req = 1'b0;
    check("sw_cause0", 32'(c0), 32'h2);
    run_to(107);
    check("sw_pre_out0", 32'(o0), 32'h0);
    step();
    check("sw_rel_out0", 32'(o0), 32'h1);

    // External drop and software request together in RELEASE: external wins.
    run_to(112);
    check("both_pre_out0", 32'(o0), 32'h3);
    res_n_in = 1'b0;
    step();
    res_n_in = 1'b1;
    sw_res_req = 1'b1;
    step();
    sw_res_req = 1'b0;
    check("both_out0", 32'(o0), 32'h0);
    check("both_cause0", 32'(c0), 32'h1);

    // res in the middle of RELEASE with two channels out.
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      step();
      if (exp_out[0] == 3) seen = 1'b1;
    end
    check("wait_0011_done", 32'(seen), 32'h1);
    res = 1'b1;
    step();
    res = 1'b0;
    check("mid_rst_out0", 32'(o0), 32'h0);
    check("mid_rst_done0", 32'(d0), 32'h0);
    check("mid_rst_cause0", 32'(c0), 32'h0);
    r = ed;
    run_to(r + 24);
    check("mid_rst_pre_out0", 32'(o0), 32'h0);
    step();
    check("mid_rst_rel_out0", 32'(o0), 32'h1);
    check("mid_rst_rel_cause0", 32'(c0), 32'h0);

    // Randomised traffic: sparse low bursts, software pulses and resets.
    low_len = 0;
    for (int k = 0; k < 4000; k++) begin
      if (low_len == 0 && $urandom_range(0, 119) == 0) low_len = $urandom_range(1, 3);
      res_n_in = (low_len == 0);
      if (low_len > 0) low_len--;
      sw_res_req = ($urandom_range(0, 79) == 0);
      res = ($urandom_range(0, 399) == 0);
      step();
    end
    res = 1'b0; sw_res_req = 1'b0; res_n_in = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/res_seq.md
RES_SEQ -- requirements
Module: res_seq

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 8, number of synchroniser flops on res_n_in (legal 2..16).
REQ-002 SHALL have parameter N_CH, default 4, number of reset output channels (legal 1..16).
REQ-003 SHALL have parameter HOLD_CYC, default 16, minimum clean-input cycles before the first release (legal 1..65535).
REQ-004 SHALL have parameter STAGGER_CYC, default 4, cycles between consecutive channel releases (legal 0..65535).
REQ-005 SHALL have port clk  input  1  single clock; all flops posedge clk.
REQ-006 SHALL have port res  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port res_n_in  input  1  asynchronous active-low external reset request.
REQ-008 SHALL have port sw_res_req  input  1  synchronous one-cycle software reset request.
REQ-009 SHALL have port res_n_out  output  N_CH  per-channel synchronous active-low resets, bit k released k-th.
REQ-010 SHALL have port seq_done  output  1  high while all channels are released.
REQ-011 SHALL have port res_cause  output  2  cause of the last sequence: 00 res, 01 external, 10 software.

Function
REQ-012 SHALL sample res_n_in through a SYNC_STAGES-deep shift chain; ext_ok = AND of all chain bits (combinational).
REQ-013 ext_ok SHALL fall one edge after res_n_in is sampled low and SHALL rise only after SYNC_STAGES consecutive high samples; a one-cycle low glitch drops ext_ok.
REQ-014 FSM states SHALL be ASSERT, HOLD, RELEASE, RUN.
REQ-015 ASSERT: all res_n_out=0, seq_done=0; on an edge with ext_ok=1 -> HOLD, cnt=0; sw_res_req ignored.
REQ-016 HOLD: cnt increments each edge; ext_ok=0 -> ASSERT, res_cause=01; sw_res_req=1 (ext_ok=1) -> cnt=0, res_cause=10, stay HOLD.
REQ-017 HOLD exit: on the edge where cnt==HOLD_CYC-1 (and no abort) -> RELEASE, res_n_out[0]=1, cnt=0, idx=1.
REQ-018 RELEASE: cnt increments each edge; on the edge where cnt==STAGGER_CYC-1, res_n_out[idx]=1, idx++, cnt=0.
REQ-019 STAGGER_CYC=0: all N_CH bits SHALL rise on the HOLD exit edge; state goes directly to RUN.
REQ-020 seq_done and state RUN SHALL be entered on the same edge that sets res_n_out[N_CH-1]; N_CH=1 enters RUN on the HOLD exit edge.
REQ-021 Released bits SHALL stay high until abort; unreleased bits stay low.
REQ-022 RELEASE or RUN abort: ext_ok=0 or sw_res_req=1 -> next edge all res_n_out=0, seq_done=0, cnt=0, state ASSERT (sw-only abort: ASSERT then HOLD next edge since ext_ok=1).
REQ-023 Simultaneous ext_ok=0 and sw_res_req=1 SHALL record res_cause=01 (external priority).
REQ-024 res_cause SHALL change only on abort/restart events and hold otherwise.
REQ-025 Counters SHALL be 16 bits; no wrap occurs since every compare terminates before overflow.

Reset
REQ-026 res=1 SHALL on the next edge clear sync chain to 0, state=ASSERT, cnt=0, idx=0, res_n_out=0, seq_done=0, res_cause=00.
REQ-027 res SHALL override every other input in every state, including mid-RELEASE.

Verification
REQ-028 Defaults, res low at edge 0, res_n_in=1 constant -> HOLD entered edge 9; res_n_out[0] rises edge 25, [1] 29, [2] 33, [3] 37 with seq_done=1 at edge 37.
REQ-029 RUN, res_n_in low 1 cycle -> res_n_out=0000 and seq_done=0 two edges after the low sample; re-release 0001 after SYNC_STAGES+HOLD_CYC+1 more edges; res_cause=01.
REQ-030 HOLD at cnt=10, sw_res_req pulse -> cnt restarts, res_n_out[0] rises 16 edges after the pulse, res_cause=10.
REQ-031 RELEASE after bit 1, ext_ok drop and sw_res_req same cycle -> all 0 next edge, res_cause=01.
REQ-032 STAGGER_CYC=0, N_CH=4 -> res_n_out 0000->1111 and seq_done=1 on one edge (edge 25).
REQ-033 res=1 asserted mid-RELEASE (res_n_out=0011) -> next edge all outputs 0, res_cause=00, sequence restarts from empty chain.
